rv32i_dmem_bridge: RTL
======================

RV32I_DMEM_BRIDGE -- requirements
Module: rv32i_dmem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles allowed per access before abort; range 1..255.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req_load  input  1  ALU load request, word-aligned.
REQ-005 SHALL have port req_store  input  1  ALU store request.
REQ-006 SHALL have port req_addr  input  32  word address; bits [1:0] are zero.
REQ-007 SHALL have port req_wdata  input  32  store data, already lane-shifted.
REQ-008 SHALL have port req_be  input  4  store byte enables.
REQ-009 SHALL have port stall  output  1  pipeline hold to the ALU and earlier stages.
REQ-010 SHALL have port ld_data  output  32  raw read word back to the ALU.
REQ-011 SHALL have port bus_err  output  1  one-cycle pulse on timeout or protocol error.
REQ-012 SHALL have ports avm_address (output, 32), avm_byteenable (output, 4), avm_writedata (output, 32), avm_read (output, 1), avm_write (output, 1) forming the data bus request.
REQ-013 SHALL have ports avm_waitrequest (input, 1), avm_readdata (input, 32), avm_readdatavalid (input, 1) forming the data bus response.

Function
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, RD_WAIT, RESP.
REQ-015 In IDLE with req_load=1, SHALL register address, set byteenable to 4'hF, and go to READ.
REQ-016 In IDLE with req_store=1 and req_load=0, SHALL register address, data and be, and go to WRITE.
REQ-017 In IDLE with req_load=1 and req_store=1, SHALL perform the load, drop the store, and pulse bus_err.
REQ-018 In WRITE, SHALL hold avm_write and the registered fields stable until it samples avm_waitrequest=0, then go to RESP.
REQ-019 In READ, SHALL hold avm_read until it samples avm_waitrequest=0.
REQ-020 When READ exits with avm_readdatavalid=1 in the same cycle, SHALL capture avm_readdata and go to RESP; otherwise SHALL go to RD_WAIT.
REQ-021 In RD_WAIT, on avm_readdatavalid=1, SHALL capture avm_readdata into ld_data and go to RESP.
REQ-022 SHALL drive avm_read and avm_write from registers, never both high, and only in READ and WRITE respectively.
REQ-023 stall SHALL be combinational: high when state is WRITE, READ or RD_WAIT, and high in IDLE while req_load or req_store is asserted; low in RESP and idle cycles.
REQ-024 RESP SHALL last exactly one cycle with stall=0, then go to IDLE; req_* sampled during RESP SHALL be ignored, because that request is the one just completed.
REQ-025 ld_data SHALL hold its last captured value until the next capture.
REQ-026 A timeout counter SHALL clear on leaving IDLE and increment each cycle in WRITE, READ or RD_WAIT.
REQ-027 When the counter reaches TIMEOUT_CYCLES, SHALL deassert the bus strobes, set ld_data=0, pulse bus_err, and go to RESP.
REQ-028 When a response and a timeout occur in the same cycle, the response SHALL win and bus_err SHALL stay 0.
REQ-029 avm_readdatavalid seen in IDLE, WRITE or RESP SHALL be ignored and SHALL pulse bus_err.
REQ-030 Zero-wait latency: request in cycle N, strobe in N+1, RESP in N+2; minimum stall is 2 cycles.

Reset
REQ-031 While reset_n=0 at a clk edge: state=IDLE, avm_read=0, avm_write=0, avm_address=0, avm_byteenable=0, avm_writedata=0, ld_data=0, bus_err=0, timeout counter=0.
REQ-032 Reset mid-access SHALL abandon the transaction with strobes low after that edge; a late avm_readdatavalid SHALL then be treated per REQ-029.

Structure
REQ-033 The state encoding and the TIMEOUT_CYCLES default SHALL live in shared package rv32_pkg.
REQ-034 The timeout counter SHALL be sub-module rv32i_dmem_timer, with inputs clear and enable and output expired.

Verification
REQ-035 Zero-wait load: addr 0x100, readdata 0xDEADBEEF valid with the strobe -> stall high 2 cycles, RESP ld_data=0xDEADBEEF.
REQ-036 Store with waitrequest high 3 cycles: be 4'b0100, data 0x00AB0000 -> avm_write high 4 cycles, fields stable, stall high 5 cycles.
REQ-037 Split read: waitrequest low, readdatavalid 4 cycles later with 0x12345678 -> RD_WAIT entered, ld_data=0x12345678 in RESP.
REQ-038 Timeout with TIMEOUT_CYCLES=8 and no readdatavalid -> bus_err single pulse, ld_data=0, FSM back in IDLE after RESP.
REQ-039 req_load and req_store together -> read only, no avm_write, bus_err pulse.
REQ-040 reset_n low during RD_WAIT, then readdatavalid -> strobes 0, state IDLE, bus_err pulse, ld_data unchanged at 0.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I data-memory bridge: FSM encoding and
// the default bus-access timeout.
package rv32_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        RD_WAIT = 3'd3,
        RESP    = 3'd4
    } dmem_state_t;

    // Bus cycles an access may spend in WRITE/READ/RD_WAIT before abort.
    localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/rv32i_dmem_timer.sv
// Access timeout counter. Cleared while the bridge is idle, counts every
// busy bus cycle, and flags the busy cycle on which the allowance runs out.
module rv32i_dmem_timer
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] count;

    // count holds the number of busy cycles already completed; the current
    // busy cycle is the last one allowed when count == LIMIT-1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (enable && !expired) begin
            count <= count + 8'd1;
        end
    end

    // Expiry is reported in the busy cycle whose increment reaches LIMIT.
    assign expired = enable && (count == (LIMIT - 8'd1));

endmodule

// File: rtl/rv32i_dmem_bridge.sv
// Bridge between the RV32I ALU load/store request and an Avalon-MM style
// data bus. One access in flight; the pipeline is stalled until RESP.
//
// Bus handshake: a request (avm_read or avm_write) is accepted on the first
// rising edge where it is high and avm_waitrequest is low; address, byte
// enables and write data stay stable until then. Read data is valid on any
// edge where avm_readdatavalid is high, which may be the acceptance edge or
// a later one (split read).
module rv32i_dmem_bridge
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall,
    output logic [31:0] ld_data,
    output logic        bus_err,
    output logic [31:0] avm_address,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [2:0]  dbg_state
);

    dmem_state_t state, state_next;
    logic [31:0] addr_next, wdata_next, ld_next;
    logic [3:0]  be_next;
    logic        err_next;
    logic        busy, expired;

    assign busy      = (state == WRITE) || (state == READ) || (state == RD_WAIT);
    assign dbg_state = state;

    rv32i_dmem_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state == IDLE),
        .enable  (busy),
        .expired (expired)
    );

    // Pipeline hold: any busy state, or an idle cycle that is taking a request.
    always_comb begin
        stall = busy || ((state == IDLE) && (req_load || req_store));
    end

    // Next-state and next-register values; the response path beats a timeout.
    always_comb begin
        state_next = state;
        addr_next  = avm_address;
        be_next    = avm_byteenable;
        wdata_next = avm_writedata;
        ld_next    = ld_data;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req_load) begin
                    addr_next  = req_addr;
                    be_next    = 4'hF;
                    state_next = READ;
                    err_next   = req_store;
                end else if (req_store) begin
                    addr_next  = req_addr;
                    be_next    = req_be;
                    wdata_next = req_wdata;
                    state_next = WRITE;
                end
                if (avm_readdatavalid) err_next = 1'b1;
            end
            WRITE: begin
                if (!avm_waitrequest) begin
                    state_next = RESP;
                end else if (expired) begin
                    state_next = RESP;
                    ld_next    = 32'd0;
                    err_next   = 1'b1;
                end
                if (avm_readdatavalid) err_next = 1'b1;
            end
            READ: begin
                if (!avm_waitrequest && avm_readdatavalid) begin
                    ld_next    = avm_readdata;
                    state_next = RESP;
                end else if (expired) begin
                    state_next = RESP;
                    ld_next    = 32'd0;
                    err_next   = 1'b1;
                end else if (!avm_waitrequest) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    ld_next    = avm_readdata;
                    state_next = RESP;
                end else if (expired) begin
                    state_next = RESP;
                    ld_next    = 32'd0;
                    err_next   = 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
                if (avm_readdatavalid) err_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, registered bus request, load data and error pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= 32'd0;
            avm_byteenable <= 4'd0;
            avm_writedata  <= 32'd0;
            ld_data        <= 32'd0;
            bus_err        <= 1'b0;
        end else begin
            state          <= state_next;
            avm_read       <= (state_next == READ);
            avm_write      <= (state_next == WRITE);
            avm_address    <= addr_next;
            avm_byteenable <= be_next;
            avm_writedata  <= wdata_next;
            ld_data        <= ld_next;
            bus_err        <= err_next;
        end
    end

endmodule
